// File: rtl/dog_scan_pkg.sv
// Shared types and width helpers for the DoG keypoint scan controller.
package dog_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DETECT,
        ST_SCAN,
        ST_UPDATE,
        ST_BUFFER,
        ST_DONE
    } scan_state_t;

    // Keypoint record, wide enough for any practical image size.
    localparam int KP_FIELD_W = 16;

    typedef struct packed {
        logic [KP_FIELD_W-1:0] row;
        logic [KP_FIELD_W-1:0] col;
    } kp_rec_t;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int col_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int kaw_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lsb_pop_encoder.sv
// Lowest-set-bit encoder: index of the lowest flag and the vector with that
// flag removed, so a caller can pop one flagged column per cycle.
module lsb_pop_encoder
    import dog_scan_pkg::*;
#(
    parameter int COLS = 640,
    parameter int CW   = col_w(COLS)
) (
    input  logic [COLS-1:0] vec,
    output logic [CW-1:0]   idx,
    output logic            valid,
    output logic [COLS-1:0] rest
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downwards so the lowest set bit writes idx last.
        for (int i = COLS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = CW'(i);
            end
        end
        rest = vec & (vec - COLS'(1));
    end

endmodule

// File: rtl/dog_keypoint_scan_ctrl.sv
// Row-scan sequencer for DoG keypoint detection: reads each row, serialises
// flagged columns per layer through the external filters and stores survivors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_READ   | waiting out the scale-SRAM read latency
// ST_DETECT | latch masked extremum flags and the window centre row
// ST_SCAN   | pop one flagged column per layer per cycle, query filters
// ST_UPDATE | advance the row or finish
// ST_BUFFER | one-cycle line-buffer shift
// ST_DONE   | one-cycle done pulse
module dog_keypoint_scan_ctrl
    import dog_scan_pkg::*;
#(
    parameter int  ROWS       = 480,
    parameter int  COLS       = 640,
    parameter int  NUM_SCALES = 5,
    parameter int  KP_DEPTH   = 2048,
    parameter int  RD_LAT     = 2,
    localparam int NUM_DET    = (NUM_SCALES > 3) ? NUM_SCALES - 3 : 1,
    localparam int RW         = row_w(ROWS),
    localparam int CW         = col_w(COLS),
    localparam int KAW        = kaw_w(KP_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        done,
    output logic                        busy,
    output logic [RW-1:0]               row_addr,
    output logic                        buffer_we,
    input  logic [NUM_DET*COLS-1:0]     det_flags,
    output logic [NUM_DET*CW-1:0]       flt_col,
    output logic [NUM_DET-1:0]          flt_valid,
    input  logic [NUM_DET-1:0]          flt_pass,
    output logic [NUM_DET-1:0]          kp_we,
    output logic [NUM_DET*KAW-1:0]      kp_addr,
    output logic [NUM_DET*(RW+CW)-1:0]  kp_din,
    output logic [NUM_DET*(KAW+1)-1:0]  kp_count,
    output logic [NUM_DET-1:0]          kp_ovf
);

    localparam int CNTW = KAW + 1;
    localparam int LW   = $clog2(RD_LAT + 1);
    localparam logic [LW-1:0] RD_LOAD = LW'(RD_LAT - 1);
    // Border columns never qualify: the 3x3 neighbourhood is incomplete there.
    localparam logic [COLS-1:0] BORDER_MASK = {1'b0, {(COLS-2){1'b1}}, 1'b0};

    scan_state_t         state;
    logic [LW-1:0]       rd_cnt;
    logic [RW-1:0]       tag_row;
    logic [COLS-1:0]     shadow    [NUM_DET];
    logic [KAW-1:0]      kp_addr_r [NUM_DET];
    logic [CNTW-1:0]     kp_cnt_r  [NUM_DET];
    logic [RW+CW-1:0]    kp_din_r  [NUM_DET];

    logic [CW-1:0]       enc_idx   [NUM_DET];
    logic [COLS-1:0]     enc_rest  [NUM_DET];
    logic [NUM_DET-1:0]  enc_valid;
    logic [NUM_DET-1:0]  kp_full;
    logic                any_flag;
    logic                window_fill;

    assign any_flag    = |enc_valid;
    assign window_fill = ((row_addr >> 1) == '0);

    // A write already in flight counts against capacity.
    always_comb begin
        kp_full = '0;
        for (int l = 0; l < NUM_DET; l++) begin
            kp_full[l] = (kp_cnt_r[l] + CNTW'(kp_we[l])) >= CNTW'(KP_DEPTH);
        end
    end

    for (genvar g = 0; g < NUM_DET; g++) begin : g_layer
        lsb_pop_encoder #(
            .COLS (COLS),
            .CW   (CW)
        ) u_enc (
            .vec   (shadow[g]),
            .idx   (enc_idx[g]),
            .valid (enc_valid[g]),
            .rest  (enc_rest[g])
        );

        assign flt_valid[g]                    = (state == ST_SCAN) && enc_valid[g];
        assign flt_col[g*CW +: CW]             = flt_valid[g] ? enc_idx[g] : '0;
        assign kp_addr[g*KAW +: KAW]           = kp_addr_r[g];
        assign kp_din[g*(RW+CW) +: RW+CW]      = kp_din_r[g];
        assign kp_count[g*CNTW +: CNTW]        = kp_cnt_r[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_cnt    <= '0;
            row_addr  <= '0;
            tag_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            buffer_we <= 1'b0;
            kp_we     <= '0;
            kp_ovf    <= '0;
            for (int l = 0; l < NUM_DET; l++) begin
                shadow[l]    <= '0;
                kp_addr_r[l] <= '0;
                kp_cnt_r[l]  <= '0;
                kp_din_r[l]  <= '0;
            end
        end else begin
            done      <= 1'b0;
            buffer_we <= 1'b0;
            kp_we     <= '0;

            // Address and count advance once the write cycle has completed.
            for (int l = 0; l < NUM_DET; l++) begin
                if (kp_we[l]) begin
                    kp_addr_r[l] <= kp_addr_r[l] + KAW'(1);
                    kp_cnt_r[l]  <= kp_cnt_r[l] + CNTW'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_addr <= '0;
                        kp_ovf   <= '0;
                        for (int l = 0; l < NUM_DET; l++) begin
                            kp_addr_r[l] <= '0;
                            kp_cnt_r[l]  <= '0;
                        end
                        rd_cnt <= RD_LOAD;
                        busy   <= 1'b1;
                        state  <= ST_READ;
                    end
                end

                ST_READ: begin
                    if (rd_cnt == '0) begin
                        state <= ST_DETECT;
                    end else begin
                        rd_cnt <= rd_cnt - LW'(1);
                    end
                end

                ST_DETECT: begin
                    tag_row <= row_addr - RW'(1);
                    for (int l = 0; l < NUM_DET; l++) begin
                        shadow[l] <= window_fill ? '0 : (det_flags[l*COLS +: COLS] & BORDER_MASK);
                    end
                    state <= ST_SCAN;
                end

                ST_SCAN: begin
                    if (!any_flag) begin
                        state <= ST_UPDATE;
                    end else begin
                        for (int l = 0; l < NUM_DET; l++) begin
                            if (enc_valid[l]) begin
                                shadow[l] <= enc_rest[l];
                                if (flt_pass[l]) begin
                                    if (kp_full[l]) begin
                                        kp_ovf[l] <= 1'b1;
                                    end else begin
                                        kp_we[l]    <= 1'b1;
                                        kp_din_r[l] <= {tag_row, enc_idx[l]};
                                    end
                                end
                            end
                        end
                    end
                end

                ST_UPDATE: begin
                    if (row_addr == RW'(ROWS - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        row_addr  <= row_addr + RW'(1);
                        buffer_we <= 1'b1;
                        state     <= ST_BUFFER;
                    end
                end

                ST_BUFFER: begin
                    rd_cnt <= RD_LOAD;
                    state  <= ST_READ;
                end

                ST_DONE: begin
                    row_addr <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dog_keypoint_scan_ctrl.sv
// Directed bench for dog_keypoint_scan_ctrl on an 8x16 image, two layers,
// four-entry keypoint SRAMs; expected values are worked out by hand below.
module tb_dog_keypoint_scan_ctrl;
    import dog_scan_pkg::*;

    localparam int ROWS       = 8;
    localparam int COLS       = 16;
    localparam int NUM_SCALES = 5;
    localparam int KP_DEPTH   = 4;
    localparam int RD_LAT     = 2;
    localparam int ND         = 2;
    localparam int RW         = 3;
    localparam int CW         = 4;
    localparam int KAW        = 2;
    localparam int CNTW       = KAW + 1;
    // Per-row cost with no flags: READ x RD_LAT, DETECT, SCAN, UPDATE, BUFFER/DONE.
    localparam int BASE_CYC   = ROWS * (RD_LAT + 4);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    done, busy, buffer_we;
    logic [RW-1:0]           row_addr;
    logic [ND*COLS-1:0]      det_flags;
    logic [ND*CW-1:0]        flt_col;
    logic [ND-1:0]           flt_valid, flt_pass, kp_we, kp_ovf;
    logic [ND*KAW-1:0]       kp_addr;
    logic [ND*(RW+CW)-1:0]   kp_din;
    logic [ND*CNTW-1:0]      kp_count;

    logic [COLS-1:0] flags_tab [ND][ROWS];
    logic [COLS-1:0] pass_map  [ND];

    int n_chk = 0;
    int n_fail = 0;

    int fcol0[$], fcyc0[$], fcol1[$];
    int wadr0[$], wdin0[$], wcyc0[$], wadr1[$], wdin1[$];

    always #5 clk = ~clk;

    dog_keypoint_scan_ctrl #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .NUM_SCALES (NUM_SCALES),
        .KP_DEPTH   (KP_DEPTH),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .row_addr  (row_addr),
        .buffer_we (buffer_we),
        .det_flags (det_flags),
        .flt_col   (flt_col),
        .flt_valid (flt_valid),
        .flt_pass  (flt_pass),
        .kp_we     (kp_we),
        .kp_addr   (kp_addr),
        .kp_din    (kp_din),
        .kp_count  (kp_count),
        .kp_ovf    (kp_ovf)
    );

    always_comb begin
        det_flags = {flags_tab[1][row_addr], flags_tab[0][row_addr]};
        flt_pass  = '0;
        for (int l = 0; l < ND; l++) begin
            flt_pass[l] = pass_map[l][flt_col[l*CW +: CW]];
        end
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int kp_word(input int row, input int col);
        kp_rec_t r;
        r.row = KP_FIELD_W'(row);
        r.col = KP_FIELD_W'(col);
        return (int'(r.row) << CW) | int'(r.col);
    endfunction

    function automatic int cnt_of(input int l);
        return int'(kp_count[l*CNTW +: CNTW]);
    endfunction

    task automatic clear_tabs();
        for (int l = 0; l < ND; l++) begin
            pass_map[l] = '1;
            for (int r = 0; r < ROWS; r++) flags_tab[l][r] = '0;
        end
    endtask

    // Start a frame and record filter queries and SRAM writes until done.
    // Cycles are counted at falling edges, the first one right after start is sampled.
    task automatic run_scan(input string tag, input int exp_cyc, input int poke_at,
                            input bit check_clear);
        int cyc  = 0;
        int nbuf = 0;
        bit seen = 1'b0;
        fcol0.delete(); fcyc0.delete(); fcol1.delete();
        wadr0.delete(); wdin0.delete(); wcyc0.delete(); wadr1.delete(); wdin1.delete();
        @(negedge clk);
        start = 1'b1;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                if (check_clear) begin
                    chk({tag, "_ovf_cleared"}, int'(kp_ovf), 0);
                    chk({tag, "_cnt0_cleared"}, cnt_of(0), 0);
                end
            end
            if (poke_at > 1) begin
                if (cyc == poke_at) start = 1'b1;
                else if (cyc == poke_at + 1) start = 1'b0;
            end
            if (buffer_we) nbuf++;
            if (flt_valid[0]) begin fcol0.push_back(int'(flt_col[0 +: CW])); fcyc0.push_back(cyc); end
            if (flt_valid[1]) fcol1.push_back(int'(flt_col[CW +: CW]));
            if (kp_we[0]) begin
                wadr0.push_back(int'(kp_addr[0 +: KAW]));
                wdin0.push_back(int'(kp_din[0 +: RW+CW]));
                wcyc0.push_back(cyc);
            end
            if (kp_we[1]) begin
                wadr1.push_back(int'(kp_addr[KAW +: KAW]));
                wdin1.push_back(int'(kp_din[RW+CW +: RW+CW]));
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_buffer_pulses"}, nbuf, ROWS - 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, int'(done), 0);
        chk({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int bad;
        int waited;
        clear_tabs();

        // Reset and quiet idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy || done || buffer_we || (|kp_we) || (|flt_valid) || (|row_addr) ||
                (|kp_count) || (|kp_ovf) || (|kp_addr) || (|kp_din) || (|flt_col))
                bad++;
        end
        chk("idle_quiet_cycles", bad, 0);
        chk("reset_busy", int'(busy), 0);

        // Empty image
        run_scan("empty", BASE_CYC, 0, 1'b0);
        chk("empty_cnt0", cnt_of(0), 0);
        chk("empty_cnt1", cnt_of(1), 0);
        chk("empty_queries", fcol0.size() + fcol1.size(), 0);

        // Border columns every row, everything on the two fill rows, plus an ignored start
        clear_tabs();
        for (int r = 0; r < ROWS; r++) begin
            flags_tab[0][r] = 16'h8001;
            flags_tab[1][r] = 16'h8001;
        end
        flags_tab[0][0] = '1; flags_tab[0][1] = '1;
        flags_tab[1][0] = '1; flags_tab[1][1] = '1;
        run_scan("border", BASE_CYC, 20, 1'b0);
        chk("border_queries", fcol0.size() + fcol1.size(), 0);
        chk("border_writes", wadr0.size() + wadr1.size(), 0);

        // Multi-column row: row 4 tags centre row 3
        clear_tabs();
        flags_tab[0][4] = (16'h1 << 3) | (16'h1 << 7) | (16'h1 << 12);
        run_scan("multi", BASE_CYC + 3, 0, 1'b0);
        chk("multi_nq", fcol0.size(), 3);
        if (fcol0.size() == 3) begin
            chk("multi_col_a", fcol0[0], 3);
            chk("multi_col_b", fcol0[1], 7);
            chk("multi_col_c", fcol0[2], 12);
            chk("multi_consec_ab", fcyc0[1] - fcyc0[0], 1);
            chk("multi_consec_bc", fcyc0[2] - fcyc0[1], 1);
        end
        chk("multi_nw", wadr0.size(), 3);
        if (wadr0.size() == 3) begin
            chk("multi_we_next_cycle", wcyc0[0], fcyc0[0] + 1);
            for (int i = 0; i < 3; i++) chk("multi_addr", wadr0[i], i);
            chk("multi_din_a", wdin0[0], kp_word(3, 3));
            chk("multi_din_b", wdin0[1], kp_word(3, 7));
            chk("multi_din_c", wdin0[2], kp_word(3, 12));
        end
        chk("multi_cnt0", cnt_of(0), 3);
        chk("multi_cnt1", cnt_of(1), 0);

        // Filter rejection, independent layers: row 5 tags centre row 4
        clear_tabs();
        flags_tab[0][5] = 16'h1 << 5;
        flags_tab[1][5] = (16'h1 << 2) | (16'h1 << 9);
        pass_map[1][2]  = 1'b0;
        run_scan("filt", BASE_CYC + 2, 0, 1'b0);
        chk("filt_l1_queries", fcol1.size(), 2);
        chk("filt_l0_queries", fcol0.size(), 1);
        chk("filt_l1_writes", wadr1.size(), 1);
        if (wadr1.size() == 1) begin
            chk("filt_l1_addr", wadr1[0], 0);
            chk("filt_l1_din", wdin1[0], kp_word(4, 9));
        end
        if (wdin0.size() == 1) chk("filt_l0_din", wdin0[0], kp_word(4, 5));
        else chk("filt_l0_writes", wdin0.size(), 1);
        chk("filt_cnt0", cnt_of(0), 1);
        chk("filt_cnt1", cnt_of(1), 1);

        // Overflow: six passing flags on row 3 (centre row 2) into a 4-deep SRAM
        clear_tabs();
        flags_tab[0][3] = 16'h007E;
        run_scan("ovf", BASE_CYC + 6, 0, 1'b0);
        chk("ovf_writes", wadr0.size(), 4);
        if (wadr0.size() == 4) begin
            chk("ovf_last_addr", wadr0[3], 3);
            chk("ovf_last_din", wdin0[3], kp_word(2, 4));
        end
        chk("ovf_cnt0_sat", cnt_of(0), KP_DEPTH);
        chk("ovf_flags", int'(kp_ovf), 1);
        chk("ovf_addr_wrapped", int'(kp_addr[0 +: KAW]), 0);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", int'(kp_ovf), 1);
        clear_tabs();
        run_scan("restart", BASE_CYC, 0, 1'b1);
        chk("restart_ovf", int'(kp_ovf), 0);

        // Asynchronous reset in the middle of a scan
        clear_tabs();
        flags_tab[0][4] = (16'h1 << 3) | (16'h1 << 7) | (16'h1 << 12);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!flt_valid[0] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_scan", int'(flt_valid[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_flt_valid", int'(flt_valid), 0);
        chk("abort_row_addr", int'(row_addr), 0);
        chk("abort_cnt0", cnt_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done || busy || (|kp_we)) bad++;
        end
        chk("abort_no_done", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
